// File: rtl/rtc_pkg.sv
`default_nettype none
// rtc_pkg: shared BCD limits, field positions and legality helper for the
// time-of-day counter.
package rtc_pkg;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;
    localparam logic [5:0] HR_MAX  = 6'h23;

    localparam int SEC_LSB = 0;
    localparam int SEC_MSB = 7;
    localparam int MIN_LSB = 8;
    localparam int MIN_MSB = 15;
    localparam int HR_LSB  = 16;
    localparam int HR_MSB  = 21;

    localparam int VALID_SEC = 0;
    localparam int VALID_MIN = 1;
    localparam int VALID_HR  = 2;

    // With the units digit capped at 9, a plain compare against the field
    // maximum also bounds the tens digit.
    function automatic logic bcd_field_legal(input logic [7:0] value, input logic [7:0] max);
        return (value[3:0] <= 4'd9) && (value <= max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_bcd_field.sv
`default_nettype none
// rtc_bcd_field: one two-digit BCD register that loads, increments and wraps
// at MAX, flagging a carry when an increment wraps it.
module rtc_bcd_field
    import rtc_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val,
    output logic             o_carry
);

    localparam logic [WIDTH-5:0] TENS_ONE = (WIDTH-4)'(1);

    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] nxt;

    always_comb begin
        nxt = val;
        if (val == MAX) begin
            nxt = '0;
        end else if (val[3:0] == 4'd9) begin
            nxt[3:0]       = 4'd0;
            nxt[WIDTH-1:4] = val[WIDTH-1:4] + TENS_ONE;
        end else begin
            nxt[3:0] = val[3:0] + 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            val <= '0;
        end else if (i_load) begin
            val <= i_val;
        end else if (i_inc) begin
            val <= nxt;
        end
    end

    assign o_val   = val;
    assign o_carry = i_inc && (val == MAX);

endmodule
`default_nettype wire

// File: rtl/rtc_timeofday.sv
`default_nettype none
// rtc_timeofday: BCD HH:MM:SS clock driven by a phase accumulator, with host
// field writes and optional GPS PPS phase realignment.
module rtc_timeofday
    import rtc_pkg::*;
#(
    parameter logic [31:0] CLOCK_STEP   = 32'd43,
    parameter logic        OPT_GPS_SYNC = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr,
    input  logic [21:0] i_data,
    input  logic [2:0]  i_valid,
    input  logic        i_gps_pps,
    output logic [21:0] o_now,
    output logic        o_pps,
    output logic        o_ppd,
    output logic [31:0] o_data
);

    logic [31:0] phase;
    logic [32:0] phase_sum;
    logic        gps_sync;
    logic        tick;
    logic        write_active;
    logic        write_sec;
    logic        advance;

    logic        load_sec, load_min, load_hr;
    logic [7:0]  sec, min;
    logic [5:0]  hr;
    logic        sec_carry, min_carry, hr_carry;

    assign gps_sync     = OPT_GPS_SYNC && i_gps_pps;
    assign phase_sum    = {1'b0, phase} + {1'b0, CLOCK_STEP};
    assign tick         = gps_sync || phase_sum[32];
    assign write_active = i_wr && (i_valid != 3'b000);
    assign write_sec    = i_wr && i_valid[VALID_SEC];
    // Any field write, even an illegal one, swallows a coincident tick.
    assign advance      = tick && !write_active;

    assign load_sec = write_sec
                   && bcd_field_legal(i_data[SEC_MSB:SEC_LSB], SEC_MAX);
    assign load_min = i_wr && i_valid[VALID_MIN]
                   && bcd_field_legal(i_data[MIN_MSB:MIN_LSB], MIN_MAX);
    assign load_hr  = i_wr && i_valid[VALID_HR]
                   && bcd_field_legal({2'b00, i_data[HR_MSB:HR_LSB]}, {2'b00, HR_MAX});

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase <= '0;
            o_pps <= 1'b0;
            o_ppd <= 1'b0;
        end else begin
            if (gps_sync || write_sec) begin
                phase <= '0;
            end else begin
                phase <= phase_sum[31:0];
            end
            o_pps <= advance;
            o_ppd <= hr_carry;
        end
    end

    rtc_bcd_field #(.WIDTH(8), .MAX(SEC_MAX)) u_sec (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (advance),
        .i_load  (load_sec),
        .i_val   (i_data[SEC_MSB:SEC_LSB]),
        .o_val   (sec),
        .o_carry (sec_carry)
    );

    // Unwritten fields must hold during a write, so the carry chain is gated
    // by the write along with the seconds increment.
    rtc_bcd_field #(.WIDTH(8), .MAX(MIN_MAX)) u_min (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (sec_carry),
        .i_load  (load_min),
        .i_val   (i_data[MIN_MSB:MIN_LSB]),
        .o_val   (min),
        .o_carry (min_carry)
    );

    rtc_bcd_field #(.WIDTH(6), .MAX(HR_MAX)) u_hr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (min_carry),
        .i_load  (load_hr),
        .i_val   (i_data[HR_MSB:HR_LSB]),
        .o_val   (hr),
        .o_carry (hr_carry)
    );

    assign o_now  = {hr, min, sec};
    assign o_data = {10'h0, o_now};

endmodule
`default_nettype wire

// File: tb/tb_rtc_timeofday.sv
`default_nettype none
// tb_rtc_timeofday: randomized scoreboard bench comparing the time-of-day
// counter against a seconds-of-day reference model.
module tb_rtc_timeofday;

    localparam logic [31:0] STEP = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr = 1'b0;
    logic [21:0] data = '0;
    logic [2:0]  valid = '0;
    logic        gps = 1'b0;
    logic [21:0] now;
    logic        pps, ppd;
    logic [31:0] rdata;

    rtc_timeofday #(.CLOCK_STEP(STEP), .OPT_GPS_SYNC(1'b1)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wr      (wr),
        .i_data    (data),
        .i_valid   (valid),
        .i_gps_pps (gps),
        .o_now     (now),
        .o_pps     (pps),
        .o_ppd     (ppd),
        .o_data    (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [21:0] now;
        logic        pps;
        logic        ppd;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    // Reference state: plain integers for time and a 64-bit phase.
    int     m_h = 0, m_m = 0, m_s = 0;
    longint m_phase = 0;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic bit legal(input int bcd, input int maxval, output int dec);
        int tens, units;
        tens  = bcd / 16;
        units = bcd % 16;
        dec   = tens * 10 + units;
        return (units <= 9) && (dec <= maxval);
    endfunction

    task automatic cycle(input logic rst, input logic w, input logic [21:0] d,
                         input logic [2:0] v, input logic g);
        exp_t   e;
        bit     tick;
        int     dec, t;
        @(negedge clk);
        reset = rst; wr = w; data = d; valid = v; gps = g;
        e.pps = 1'b0;
        e.ppd = 1'b0;
        if (rst) begin
            m_h = 0; m_m = 0; m_s = 0; m_phase = 0;
        end else begin
            tick = g || (m_phase + longint'(STEP) >= 64'd4294967296);
            if ((w && v[0]) || g) m_phase = 0;
            else m_phase = (m_phase + longint'(STEP)) % 64'd4294967296;
            if (w && v != 3'b000) begin
                if (v[0] && legal(int'(d[7:0]), 59, dec))   m_s = dec;
                if (v[1] && legal(int'(d[15:8]), 59, dec))  m_m = dec;
                if (v[2] && legal(int'(d[21:16]), 23, dec)) m_h = dec;
            end else if (tick) begin
                t = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
                e.pps = 1'b1;
                e.ppd = (t == 0);
            end
        end
        begin
            logic [7:0] hb;
            hb = to_bcd(m_h);
            e.now = {hb[5:0], to_bcd(m_m), to_bcd(m_s)};
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 3'b000, 1'b0);
    endtask

    // Monitor: outputs are presented every cycle, one expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                compared++;
                if (now !== e.now || pps !== e.pps || ppd !== e.ppd) begin
                    mismatched++;
                    $display("FAIL time/pulses @%0t: got now=%h pps=%b ppd=%b, want now=%h pps=%b ppd=%b",
                             $time, now, pps, ppd, e.now, e.pps, e.ppd);
                end
                compared++;
                if (rdata !== {10'h0, e.now}) begin
                    mismatched++;
                    $display("FAIL readback @%0t: got %h, want %h", $time, rdata, {10'h0, e.now});
                end
            end
        end
    end

    initial begin
        int     n;
        logic [21:0] d;
        cycle(1'b1, 1'b0, '0, 3'b000, 1'b0);
        cycle(1'b1, 1'b0, '0, 3'b000, 1'b0);
        idle(13);

        cycle(1'b0, 1'b1, 22'h235958, 3'b111, 1'b0);
        idle(10);

        cycle(1'b0, 1'b1, 22'h120030, 3'b111, 1'b0);
        cycle(1'b0, 1'b1, 22'h00007A, 3'b001, 1'b0);
        cycle(1'b0, 1'b1, 22'h240000, 3'b100, 1'b0);
        idle(6);

        // Minutes write landing exactly on a tick cycle.
        cycle(1'b0, 1'b1, 22'h101010, 3'b111, 1'b0);
        n = 0;
        while (m_phase + longint'(STEP) < 64'd4294967296 && n < 8) begin
            idle(1);
            n++;
        end
        cycle(1'b0, 1'b1, 22'h004500, 3'b010, 1'b0);
        idle(5);

        // GPS pulse at half-second phase.
        n = 0;
        while (m_phase != 64'h8000_0000 && n < 8) begin
            idle(1);
            n++;
        end
        cycle(1'b0, 1'b0, '0, 3'b000, 1'b1);
        idle(9);

        // GPS coincident with a seconds write.
        cycle(1'b0, 1'b1, 22'h000033, 3'b001, 1'b1);
        idle(5);

        cycle(1'b0, 1'b1, 22'h095959, 3'b111, 1'b0);
        idle(2);
        cycle(1'b1, 1'b0, '0, 3'b000, 1'b0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                cycle(1'b1, 1'b0, '0, 3'b000, 1'b0);
            end else if ($urandom_range(5) == 0) begin
                if ($urandom_range(1) == 0) begin
                    logic [7:0] hb, mb, sb;
                    hb = to_bcd(int'($urandom_range(23)));
                    mb = to_bcd(int'($urandom_range(59)));
                    sb = to_bcd(int'($urandom_range(59)));
                    d = {hb[5:0], mb, sb};
                end else begin
                    d = 22'($urandom);
                end
                cycle(1'b0, 1'b1, d, 3'($urandom_range(7)), $urandom_range(9) == 0);
            end else begin
                cycle(1'b0, 1'b0, 22'($urandom), 3'($urandom_range(7)), $urandom_range(9) == 0);
            end
        end

        @(negedge clk);
        @(negedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
